// File: rtl/zion_basic_circuit_lib_rr_reg_arb.sv
// Round-robin write arbiter in front of one shared enabled register.
// Define ZION_RR_REG_ARB_LOCK_EN to add the iLock port and a lock-owner FSM.
module zion_basic_circuit_lib_rr_reg_arb #(
  parameter int                NUM_REQ  = 4,
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  INI_DATA = '0,
  // Derived from NUM_REQ; leave at its default.
  parameter int                IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       iVld,
  input  logic [NUM_REQ*WIDTH-1:0] iDat,
`ifdef ZION_RR_REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       iLock,
`endif
  output logic [NUM_REQ-1:0]       oRdy,
  output logic [WIDTH-1:0]         oDat,
  output logic [IDX_W-1:0]         oGntIdx,
  output logic                     oUpd
);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : gBadNumReq
    $error("NUM_REQ must be within 2..16");
  end

`ifdef ZION_RR_REG_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e           state_q;
  logic [IDX_W-1:0] own_q;
`endif

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [IDX_W-1:0] gntIdx_q;
  logic             upd_q;

  logic [IDX_W-1:0] rrIdx, gntIdx;
  logic             rrFound, gntVld, wrEn;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    rrFound = 1'b0;
    rrIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rrFound && iVld[idx]) begin
        rrFound = 1'b1;
        rrIdx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    gntIdx = rrIdx;
    gntVld = rrFound;
`ifdef ZION_RR_REG_ARB_LOCK_EN
    if (state_q == LOCKED) begin
      gntIdx = own_q;
      gntVld = iVld[own_q];
    end
`endif
    oRdy = '0;
    if (gntVld && !rst) oRdy[gntIdx] = 1'b1;
  end

  assign wrEn  = |(iVld & oRdy);
  assign dat_d = iDat[int'(gntIdx)*WIDTH +: WIDTH];
  assign ptr_d = (gntIdx == IDX_W'(NUM_REQ-1)) ? '0 : gntIdx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q    <= INI_DATA;
      gntIdx_q <= '0;
      upd_q    <= 1'b0;
      ptr_q    <= '0;
`ifdef ZION_RR_REG_ARB_LOCK_EN
      state_q  <= IDLE;
      own_q    <= '0;
`endif
    end else begin
      upd_q <= wrEn;
      if (wrEn) begin
        dat_q    <= dat_d;
        gntIdx_q <= gntIdx;
      end
`ifdef ZION_RR_REG_ARB_LOCK_EN
      // A locking write parks ptr; it moves past the owner only on release.
      case (state_q)
        IDLE: begin
          if (wrEn) begin
            if (iLock[gntIdx]) begin
              state_q <= LOCKED;
              own_q   <= gntIdx;
            end else begin
              ptr_q <= ptr_d;
            end
          end
        end
        LOCKED: begin
          if (!iLock[own_q]) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
`else
      if (wrEn) ptr_q <= ptr_d;
`endif
    end
  end

  assign oDat    = dat_q;
  assign oGntIdx = gntIdx_q;
  assign oUpd    = upd_q;

endmodule

// File: tb/tb_zion_basic_circuit_lib_rr_reg_arb.sv
// Self-checking bench for zion_basic_circuit_lib_rr_reg_arb (NUM_REQ=4, WIDTH=8, INI_DATA=8'hA5).
// Lock scenarios run only when ZION_RR_REG_ARB_LOCK_EN is defined.
module tb_zion_basic_circuit_lib_rr_reg_arb;

  typedef struct {
    logic [7:0] dat;
    logic [1:0] idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  iVld;
  logic [31:0] iDat;
  logic [3:0]  oRdy;
  logic [7:0]  oDat;
  logic [1:0]  oGntIdx;
  logic        oUpd;
`ifdef ZION_RR_REG_ARB_LOCK_EN
  logic [3:0]  iLock;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [7:0] mDat;
  logic [1:0] mIdx;

  zion_basic_circuit_lib_rr_reg_arb #(
    .NUM_REQ (4),
    .WIDTH   (8),
    .INI_DATA(8'hA5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iVld   (iVld),
    .iDat   (iDat),
`ifdef ZION_RR_REG_ARB_LOCK_EN
    .iLock  (iLock),
`endif
    .oRdy   (oRdy),
    .oDat   (oDat),
    .oGntIdx(oGntIdx),
    .oUpd   (oUpd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One arbitration cycle; expGnt < 0 means no grant is expected.
  task automatic cycle(input logic [3:0] vld, input logic [31:0] dat,
                       input logic [3:0] lock, input int expGnt);
    logic [3:0] expRdy;
    logic       expUpd;
    exp_t       e;
    iVld = vld;
    iDat = dat;
`ifdef ZION_RR_REG_ARB_LOCK_EN
    iLock = lock;
`else
    if (lock != 4'b0) $display("[TB] lock stimulus ignored in this build");
`endif
    expRdy = (expGnt >= 0) ? 4'(1 << expGnt) : 4'b0;
    @(negedge clk);
    total++;
    if (oRdy !== expRdy) begin
      bad++;
      $display("[TB] FAIL oRdy got=%b exp=%b", oRdy, expRdy);
    end
    if (expGnt >= 0) begin
      e.dat = dat[expGnt*8 +: 8];
      e.idx = 2'(expGnt);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    expUpd = 1'b0;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      mDat   = e.dat;
      mIdx   = e.idx;
      expUpd = 1'b1;
    end
    total++;
    if (oUpd !== expUpd) begin
      bad++;
      $display("[TB] FAIL oUpd got=%b exp=%b", oUpd, expUpd);
    end
    total++;
    if (oDat !== mDat) begin
      bad++;
      $display("[TB] FAIL oDat got=%h exp=%h", oDat, mDat);
    end
    total++;
    if (oGntIdx !== mIdx) begin
      bad++;
      $display("[TB] FAIL oGntIdx got=%0d exp=%0d", oGntIdx, mIdx);
    end
  endtask

  task automatic test_reset();
    total++;
    if (oDat !== 8'hA5 || oGntIdx !== 2'd0 || oUpd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got dat=%h idx=%0d upd=%b exp dat=a5 idx=0 upd=0",
               oDat, oGntIdx, oUpd);
    end
    total++;
    if (oRdy !== 4'b0) begin
      bad++;
      $display("[TB] FAIL reset_rdy got=%b exp=0000", oRdy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_contention();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
      cycle(4'b1111, d, 4'b0, i % 4);
    end
  endtask

  task automatic test_single();
    cycle(4'b0100, 32'h00_3C_00_00, 4'b0, 2);
  endtask

  task automatic test_wrap();
    cycle(4'b1001, 32'h77_00_00_11, 4'b0, 3);
    cycle(4'b1001, 32'h88_00_00_22, 4'b0, 0);
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 5; i++) cycle(4'b0000, 32'hDEAD_BEEF, 4'b0, -1);
    cycle(4'b1111, 32'h44_33_55_66, 4'b0, 1);
  endtask

  task automatic test_mid_reset();
    iVld = 4'b1111;
    iDat = 32'h01_02_03_04;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (oDat !== 8'hA5 || oGntIdx !== 2'd0 || oUpd !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs got dat=%h idx=%0d upd=%b exp dat=a5 idx=0 upd=0",
               oDat, oGntIdx, oUpd);
    end
    @(negedge clk);
    total++;
    if (oRdy !== 4'b0) begin
      bad++;
      $display("[TB] FAIL midreset_rdy got=%b exp=0000", oRdy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mDat = 8'hA5;
    mIdx = 2'd0;
    cycle(4'b0110, 32'h00_9A_5B_00, 4'b0, 1);
  endtask

`ifdef ZION_RR_REG_ARB_LOCK_EN
  task automatic test_lock();
    cycle(4'b0010, 32'h00_00_61_00, 4'b0010, 1);
    for (int i = 0; i < 4; i++)
      cycle(4'b1111, {8'hE0, 8'hD0, 8'h70 + 8'(i), 8'hC0}, 4'b0010, 1);
    cycle(4'b1111, 32'hE1_D1_7F_C1, 4'b0000, 1);
    cycle(4'b1111, 32'hE2_D2_72_C2, 4'b0000, 2);
  endtask
`endif

  initial begin
    rst  = 1'b1;
    iVld = 4'b0;
    iDat = '0;
`ifdef ZION_RR_REG_ARB_LOCK_EN
    iLock = 4'b0;
`endif
    mDat = 8'hA5;
    mIdx = 2'd0;
    #12;
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_idle_hold();
    test_mid_reset();
`ifdef ZION_RR_REG_ARB_LOCK_EN
    iVld = 4'b0;
    rst  = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mDat = 8'hA5;
    mIdx = 2'd0;
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
